ram_access_arbiter: RTL

//  Sequences every access to the single-port ram block (program ROM + data RAM behind one address register).

---
 rtl/ram_access_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ram_access_arbiter.sv
// Round-robin sequencer for the shared single-port program ROM / data RAM.
// Ports: fetch and data requesters in, ram address/enable/select controls out.
//
// Requesters:
//   i_fetchReq / i_fetchAddress          -> o_fetchData / o_fetchDone
//   i_dataReq / i_dataWrite / i_dataAddress / i_dataWriteData
//                                        -> o_dataReadData / o_dataDone
// RAM side:
//   o_ramAddress, o_ramAddressEn, o_ramWriteData, o_ramWriteEn,
//   o_ramReadDataSelect, o_ramOutEnable  <- i_ramReadData
// Status: o_busy is high whenever an access is in flight.
module ram_access_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1,
  parameter bit FETCH_FIRST = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_fetchReq,
  input  logic [ADDR_WIDTH-1:0] i_fetchAddress,
  output logic [DATA_WIDTH-1:0] o_fetchData,
  output logic                  o_fetchDone,
  input  logic                  i_dataReq,
  input  logic                  i_dataWrite,
  input  logic [ADDR_WIDTH-1:0] i_dataAddress,
  input  logic [DATA_WIDTH-1:0] i_dataWriteData,
  output logic [DATA_WIDTH-1:0] o_dataReadData,
  output logic                  o_dataDone,
  output logic [ADDR_WIDTH-1:0] o_ramAddress,
  output logic                  o_ramAddressEn,
  output logic [DATA_WIDTH-1:0] o_ramWriteData,
  output logic                  o_ramWriteEn,
  output logic                  o_ramReadDataSelect,
  output logic                  o_ramOutEnable,
  input  logic [DATA_WIDTH-1:0] i_ramReadData,
  output logic                  o_busy
);

  localparam int CW =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(WAIT_CYCLES - 1);

  // Port identifiers used for grant and last-grant.
  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    last_q, last_d;
  logic                    gnt_q, gnt_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   fdata_q, fdata_d;
  logic [DATA_WIDTH-1:0]   ddata_q, ddata_d;
  logic                    pick;
  logic                    cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  // Data wins when it is the only requester, or on a
  // tie when fetch was the last port served.
  assign pick = i_dataReq &
    (~i_fetchReq | (last_q == PORT_F));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= FETCH_FIRST ? PORT_D : PORT_F;
      gnt_q   <= PORT_F;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fdata_q <= '0;
      ddata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fdata_q <= fdata_d;
      ddata_q <= ddata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fdata_d = fdata_q;
    ddata_d = ddata_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_fetchReq || i_dataReq) begin
          gnt_d   = pick;
          last_d  = pick;
          addr_d  = pick ? i_dataAddress
                         : i_fetchAddress;
          wr_d    = pick & i_dataWrite;
          wdata_d = pick ? i_dataWriteData
                         : '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_d   = '0;
        state_d = wr_q ? S_WRITE : S_READ;
      end
      S_READ: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = S_DONE;
          if (gnt_q == PORT_D) begin
            ddata_d = i_ramReadData;
          end else begin
            fdata_d = i_ramReadData;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore decode: ram-side controls depend only on
  // registered state and the latched request.
  always_comb begin
    o_ramAddress        = '0;
    o_ramAddressEn      = 1'b0;
    o_ramWriteData      = '0;
    o_ramWriteEn        = 1'b0;
    o_ramReadDataSelect = 1'b0;
    o_ramOutEnable      = 1'b0;
    o_fetchDone         = 1'b0;
    o_dataDone          = 1'b0;
    o_busy              = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        o_busy = 1'b0;
      end
      S_ADDR: begin
        o_busy              = 1'b1;
        o_ramAddress        = addr_q;
        o_ramWriteData      = wdata_q;
        o_ramReadDataSelect = gnt_q;
        o_ramAddressEn      = 1'b1;
      end
      S_READ: begin
        o_busy              = 1'b1;
        o_ramAddress        = addr_q;
        o_ramWriteData      = wdata_q;
        o_ramReadDataSelect = gnt_q;
        o_ramOutEnable      = 1'b1;
      end
      S_WRITE: begin
        o_busy              = 1'b1;
        o_ramAddress        = addr_q;
        o_ramWriteData      = wdata_q;
        o_ramReadDataSelect = gnt_q;
        o_ramWriteEn        = 1'b1;
      end
      S_DONE: begin
        o_busy              = 1'b1;
        o_ramAddress        = addr_q;
        o_ramWriteData      = wdata_q;
        o_ramReadDataSelect = gnt_q;
        o_fetchDone         = (gnt_q == PORT_F);
        o_dataDone          = (gnt_q == PORT_D);
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  assign o_fetchData    = fdata_q;
  assign o_dataReadData = ddata_q;

endmodule
